// File: rtl/serial_pair_transmitter_msb_first.sv
// Serialises operand pairs (A, B) MSB first as parallel bit pairs with valid/ready on both sides.
// One shift stage plus one holding slot keeps the output streaming without gaps between words.
module serial_pair_transmitter_msb_first #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sh_full_q, sh_full_d;
    logic [WIDTH-1:0] hold_a_q, hold_a_d;
    logic [WIDTH-1:0] hold_b_q, hold_b_d;
    logic             hold_full_q, hold_full_d;

    logic in_xfer, out_xfer, at_last, last_xfer, direct_load;

    // Outputs are gated by rst so they read zero during the reset cycle itself.
    always_comb begin
        out_valid = rst & sh_full_q;
        out_a     = out_valid & sh_a_q[WIDTH-1];
        out_b     = out_valid & sh_b_q[WIDTH-1];
        out_first = out_valid & (cnt_q == '0);
        out_last  = out_valid & (cnt_q == CNT_LAST);
        in_ready  = rst & ~hold_full_q;
        busy      = rst & (sh_full_q | hold_full_q);
    end

    always_comb begin
        in_xfer     = in_valid & in_ready;
        out_xfer    = out_valid & out_ready;
        at_last     = cnt_q == CNT_LAST;
        last_xfer   = out_xfer & at_last;
        direct_load = in_xfer & (~sh_full_q | last_xfer);

        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        cnt_d       = cnt_q;
        sh_full_d   = sh_full_q;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        hold_full_d = hold_full_q;

        if (direct_load) begin
            sh_a_d    = in_a;
            sh_b_d    = in_b;
            cnt_d     = '0;
            sh_full_d = 1'b1;
        end else if (last_xfer) begin
            if (hold_full_q) begin
                sh_a_d      = hold_a_q;
                sh_b_d      = hold_b_q;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end else begin
                sh_full_d = 1'b0;
                cnt_d     = '0;
            end
        end else if (out_xfer) begin
            sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
            sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
        end

        // A non-direct accept can only happen while the slot is empty, so it never races the drain above.
        if (in_xfer && !direct_load) begin
            hold_a_d    = in_a;
            hold_b_d    = in_b;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cnt_q       <= '0;
            sh_full_q   <= 1'b0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            cnt_q       <= cnt_d;
            sh_full_q   <= sh_full_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_serial_pair_transmitter_msb_first.sv
// Bench for serial_pair_transmitter_msb_first: word-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_serial_pair_transmitter_msb_first;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_ready = 1'b0;
    logic         out_valid, out_a, out_b, out_first, out_last, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nrdy0 = 0;

    // Reference model: words accepted but not yet fully emitted, and bit position of the head word.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           idx = 0;

    // Log of every output transfer.
    logic lg_a[$];
    logic lg_b[$];
    logic lg_f[$];
    logic lg_l[$];
    int   lg_c[$];

    serial_pair_transmitter_msb_first #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_ready(out_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit ix, ox;
        cyc++;
        if (!rst) begin
            qa.delete();
            qb.delete();
            idx = 0;
        end else begin
            ix = in_valid && (qa.size() < 2);
            ox = (qa.size() > 0) && out_ready;
            if (ox) begin
                if (idx == W - 1) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            if (ix) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
            end
        end
    end

    always @(negedge clk) begin
        logic         ev, ea, eb, ef, el;
        logic [W-1:0] wa, wb;
        ev = rst && (qa.size() > 0);
        ea = 1'b0; eb = 1'b0; ef = 1'b0; el = 1'b0;
        if (ev) begin
            wa = qa[0];
            wb = qb[0];
            ea = wa[W-1-idx];
            eb = wb[W-1-idx];
            ef = (idx == 0);
            el = (idx == W - 1);
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_a", 32'(out_a), 32'(ea));
        chk("out_b", 32'(out_b), 32'(eb));
        chk("out_first", 32'(out_first), 32'(ef));
        chk("out_last", 32'(out_last), 32'(el));
        chk("in_ready", 32'(in_ready), 32'(rst && (qa.size() < 2)));
        chk("busy", 32'(busy), 32'(rst && (qa.size() > 0)));
        if (out_valid && out_ready) begin
            lg_a.push_back(out_a);
            lg_b.push_back(out_b);
            lg_f.push_back(out_first);
            lg_l.push_back(out_last);
            lg_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lg_clear();
        lg_a.delete(); lg_b.delete(); lg_f.delete(); lg_l.delete(); lg_c.delete();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) nrdy0++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_last(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_last && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_last) chk(nm, 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] log_word_a(input int base);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[W-1-i] = lg_a[base+i];
        return v;
    endfunction

    initial begin
        logic [W-1:0] va, vb, vf, vl;
        int neq;

        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // A5 / 3C single word at full rate
        out_ready = 1'b1;
        lg_clear();
        send(8'hA5, 8'h3C);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_first", 32'(out_first), 32'd1);
        repeat (10) step();
        chk("a5_count", 32'(lg_a.size()), 32'd8);
        if (lg_a.size() == 8) begin
            for (int i = 0; i < W; i++) begin
                va[W-1-i] = lg_a[i];
                vb[W-1-i] = lg_b[i];
                vf[W-1-i] = lg_f[i];
                vl[W-1-i] = lg_l[i];
            end
            chk("a5_bits_a", 32'(va), 32'h0A5);
            chk("a5_bits_b", 32'(vb), 32'h03C);
            chk("a5_first", 32'(vf), 32'h080);
            chk("a5_last", 32'(vl), 32'h001);
            chk("a5_span", 32'(lg_c[7] - lg_c[0]), 32'd7);
        end

        // three words back-to-back
        lg_clear();
        nrdy0 = 0;
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        send(8'h55, 8'h66);
        repeat (30) step();
        chk("b2b_count", 32'(lg_a.size()), 32'd24);
        if (lg_a.size() == 24) begin
            chk("b2b_span", 32'(lg_c[23] - lg_c[0]), 32'd23);
            chk("b2b_word2", 32'(log_word_a(8)), 32'h033);
        end
        chk("b2b_saw_not_ready", 32'(nrdy0 > 0), 32'd1);

        // out_ready alternating
        lg_clear();
        send(8'hC3, 8'h96);
        for (int i = 0; i < 16; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b0;
        chk("alt_count", 32'(lg_a.size()), 32'd8);
        if (lg_a.size() == 8) begin
            chk("alt_span", 32'(lg_c[7] - lg_c[0]), 32'd14);
            chk("alt_word", 32'(log_word_a(0)), 32'h0C3);
        end
        out_ready = 1'b1;
        repeat (4) step();

        // reset after third bit with holding slot full
        lg_clear();
        send(8'hE7, 8'h18);
        send(8'h7E, 8'h81);
        repeat (2) step();
        chk("rst3_hold_full", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst3_gate_valid", 32'(out_valid), 32'd0);
        step();
        chk("rst3_valid", 32'(out_valid), 32'd0);
        chk("rst3_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst3_ready", 32'(in_ready), 32'd1);
        repeat (12) step();
        chk("rst3_emitted", 32'(lg_a.size()), 32'd3);

        // held word enters on last-bit transfer while a third word waits
        send(8'hF0, 8'h00);
        send(8'h8F, 8'hFF);
        in_valid = 1'b1;
        in_a = 8'h3C;
        in_b = 8'hC3;
        wait_last("hold_last_timeout");
        chk("hold_rdy_at_last", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("hold_first", 32'(out_first), 32'd1);
        chk("hold_msb", 32'(out_a), 32'd1);
        chk("hold_rdy_next", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        repeat (20) step();

        // equal operands, then idle after last bit
        lg_clear();
        send(8'h5A, 8'h5A);
        wait_last("eq_last_timeout");
        @(negedge clk);
        chk("eq_idle_after_last", 32'(out_valid), 32'd0);
        neq = 0;
        for (int i = 0; i < lg_a.size(); i++) if (lg_a[i] !== lg_b[i]) neq++;
        chk("eq_count", 32'(lg_a.size()), 32'd8);
        chk("eq_a_eq_b", 32'(neq), 32'd0);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = $urandom_range(0, 9) < 7;
            rst       = $urandom_range(0, 199) != 0;
            step();
        end
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_pair_transmitter_msb_first.md
SERIAL_PAIR_TRANSMITTER_MSB_FIRST -- requirements
Module: serial_pair_transmitter_msb_first

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port in_valid, input, 1 bit: the producer offers an operand pair.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-006 The block SHALL have port in_a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port in_b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream serial consumer takes the current bit pair.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_a/out_b carry a valid bit pair.
REQ-010 The block SHALL have ports out_a and out_b, output, 1 bit each: the current bits of A and B, most significant first.
REQ-011 The block SHALL have port out_first, output, 1 bit: the current bit pair is the MSB (bit WIDTH-1) of its word.
REQ-012 The block SHALL have port out_last, output, 1 bit: the current bit pair is the LSB (bit 0) of its word.
REQ-013 The block SHALL have port busy, output, 1 bit: the block holds an unfinished or queued word.

Function
REQ-014 Storage SHALL be one shift stage (A/B shift registers plus a bit counter 0..WIDTH-1) and one holding slot (A/B words plus a full flag).
REQ-015 in_ready SHALL equal NOT hold_full while rst=1.
REQ-016 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 On an input transfer, the word SHALL load directly into the shift stage if the shift stage is empty or is completing an output transfer with out_last=1 on the same edge; otherwise it SHALL load into the holding slot.
REQ-019 On an output transfer with out_last=1, and with no direct load, a full holding slot SHALL move into the shift stage and hold_full SHALL clear; otherwise the shift stage SHALL become empty.
REQ-020 Latency: a word accepted at edge N into an empty shift stage SHALL present its MSB (out_valid=1, out_first=1) in the cycle after edge N.
REQ-021 out_valid SHALL be 1 exactly when the shift stage holds a word; out_a/out_b SHALL be the shift registers' bit WIDTH-1.
REQ-022 On each output transfer with out_last=0, both shift registers SHALL shift left by one and the counter SHALL increment by 1.
REQ-023 out_first SHALL be 1 exactly when out_valid=1 and counter=0; out_last SHALL be 1 exactly when out_valid=1 and counter=WIDTH-1.
REQ-024 The counter SHALL reset to 0 on every load into the shift stage and SHALL never exceed WIDTH-1.
REQ-025 When out_valid=1 and out_ready=0, out_a, out_b, out_first and out_last SHALL hold stable.
REQ-026 With out_ready held at 1 and a continuous supply of words, consecutive words SHALL stream with no idle cycle between one word's last bit and the next word's first bit.
REQ-027 Simultaneous events: if the holding slot is full while a last-bit transfer occurs, in_ready SHALL still be 0 that cycle, the held word SHALL enter the shift stage, and in_ready SHALL be 1 in the following cycle.
REQ-028 When out_valid=0, out_a, out_b, out_first and out_last SHALL be 0.
REQ-029 busy SHALL equal out_valid OR hold_full.

Reset
REQ-030 While rst=0 at a rising edge, the shift stage and holding slot SHALL be emptied, the counter SHALL clear, and any in-flight or queued word SHALL be discarded without being emitted.
REQ-031 While rst=0, in_ready, out_valid, out_a, out_b, out_first, out_last and busy SHALL all be 0.
REQ-032 In the first cycle after rst returns to 1, in_ready SHALL be 1 and out_valid SHALL be 0.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, in_a=8'hA5, in_b=8'h3C, out_ready=1 -> out_a 1,0,1,0,0,1,0,1 and out_b 0,0,1,1,1,1,0,0 on 8 consecutive cycles, out_first on bit 1, out_last on bit 8.
REQ-034 The bench SHALL cover: three words presented back-to-back with in_valid=1 and out_ready=1 -> 24 consecutive out_valid cycles with no gap, and in_ready=0 while the holding slot is full.
REQ-035 The bench SHALL cover: out_ready alternating 1,0,1,0 during one word -> outputs stable in the 0 cycles and all 8 bits delivered in 16 cycles.
REQ-036 The bench SHALL cover: rst=0 after the third bit of a word, with the holding slot full -> out_valid=0 and busy=0 in the next cycle, in_ready=1 after release, and neither word ever emitted.
REQ-037 The bench SHALL cover: holding slot full, last bit transferred, in_valid=1 -> in_ready=0 that cycle, the held word's MSB with out_first=1 in the next cycle, and in_ready=1 in that same next cycle.
REQ-038 The bench SHALL cover: in_a=in_b=8'h5A -> out_a equals out_b on every bit, and out_valid=0 one cycle after out_last when no further word is offered.
